// File: rtl/count_sequence_checker.sv
// ============================================================================
// count_sequence_checker
// Receive-side checker for the free-running counter pattern. Locks after a
// run of consecutive +1 samples, then flags every sample that breaks the
// sequence and keeps a saturating error total.
// Optional: define COUNT_SEQUENCE_CHECKER_STATS_EN to add o_good_count, a
// saturating count of matching samples while locked.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module count_sequence_checker #(
    parameter int P_COUNT_W = 16,
    parameter int P_LOCK_N  = 4,
    parameter int P_LOSS_N  = 3,
    parameter int P_ERR_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [P_COUNT_W-1:0] i_count,
    input  logic                 i_clear_err,
    output logic                 o_locked,
    output logic                 o_error,
    output logic [P_ERR_W-1:0]   o_err_count
`ifdef COUNT_SEQUENCE_CHECKER_STATS_EN
    ,
    output logic [P_ERR_W-1:0]   o_good_count
`endif
);

    localparam int RUN_W = $clog2(P_LOCK_N + 1);
    localparam int BAD_W = $clog2(P_LOSS_N + 1);

    // run value at which one more good sample completes the lock run
    localparam logic [RUN_W-1:0]     LOCK_LAST = RUN_W'(P_LOCK_N - 1);
    // bad_run value at which one more mismatch drops lock
    localparam logic [BAD_W-1:0]     BAD_LAST  = BAD_W'(P_LOSS_N - 1);
    localparam logic [RUN_W-1:0]     RUN_ONE   = RUN_W'(1);
    localparam logic [BAD_W-1:0]     BAD_ONE   = BAD_W'(1);
    localparam logic [P_COUNT_W-1:0] COUNT_ONE = P_COUNT_W'(1);
    localparam logic [P_ERR_W-1:0]   ERR_ONE   = P_ERR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEEK   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [P_COUNT_W-1:0] expected;
    logic [P_COUNT_W-1:0] expected_nxt;
    logic [RUN_W-1:0]     run;
    logic [RUN_W-1:0]     run_nxt;
    logic [BAD_W-1:0]     bad_run;
    logic [BAD_W-1:0]     bad_run_nxt;
    logic                 error_nxt;
    logic                 good_hit;
    logic                 match;
    logic [P_ERR_W-1:0]   err_base;
    logic [P_ERR_W-1:0]   err_nxt;

    assign match    = (i_count == expected);
    assign o_locked = (state == S_LOCKED);

    // State and tracking registers; reset wins over every other input
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            expected    <= '0;
            run         <= '0;
            bad_run     <= '0;
            o_error     <= 1'b0;
            o_err_count <= '0;
        end else begin
            state       <= state_nxt;
            expected    <= expected_nxt;
            run         <= run_nxt;
            bad_run     <= bad_run_nxt;
            o_error     <= error_nxt;
            o_err_count <= err_nxt;
        end
    end

    // Next-state logic: acquire in SEEK, free-run the expectation in LOCKED
    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        run_nxt      = run;
        bad_run_nxt  = bad_run;
        error_nxt    = 1'b0;
        good_hit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    expected_nxt = i_count + COUNT_ONE;
                    run_nxt      = RUN_ONE;
                    state_nxt    = S_SEEK;
                end
            end
            S_SEEK: begin
                if (i_valid) begin
                    expected_nxt = i_count + COUNT_ONE;
                    if (match) begin
                        run_nxt = run + RUN_ONE;
                        if (run == LOCK_LAST) begin
                            state_nxt   = S_LOCKED;
                            bad_run_nxt = '0;
                        end
                    end else begin
                        // resync silently on the new value
                        run_nxt = RUN_ONE;
                    end
                end
            end
            S_LOCKED: begin
                if (i_valid) begin
                    expected_nxt = expected + COUNT_ONE;
                    if (match) begin
                        bad_run_nxt = '0;
                        good_hit    = 1'b1;
                    end else begin
                        error_nxt = 1'b1;
                        if (bad_run == BAD_LAST) begin
                            state_nxt    = S_SEEK;
                            expected_nxt = i_count + COUNT_ONE;
                            run_nxt      = RUN_ONE;
                        end else begin
                            bad_run_nxt = bad_run + BAD_ONE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Error total: clear applies first, then a new error is counted (saturating)
    always_comb begin
        err_base = i_clear_err ? '0 : o_err_count;
        err_nxt  = err_base;
        if (error_nxt && (err_base != '1)) begin
            err_nxt = err_base + ERR_ONE;
        end
    end

`ifdef COUNT_SEQUENCE_CHECKER_STATS_EN
    logic [P_ERR_W-1:0] good_base;
    logic [P_ERR_W-1:0] good_nxt;

    // Good-sample total: same clear-then-count rule as the error total
    always_comb begin
        good_base = i_clear_err ? '0 : o_good_count;
        good_nxt  = good_base;
        if (good_hit && (good_base != '1)) begin
            good_nxt = good_base + ERR_ONE;
        end
    end

    // Good-sample register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_good_count <= '0;
        end else begin
            o_good_count <= good_nxt;
        end
    end
`else
    logic unused_good_hit;
    assign unused_good_hit = good_hit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_count_sequence_checker.sv
// ============================================================================
// tb_count_sequence_checker
// Directed self-checking bench for count_sequence_checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_sequence_checker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: default parameters
    logic        a_reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [15:0] a_count = '0;
    logic        a_clear = 1'b0;
    logic        a_locked;
    logic        a_error;
    logic [15:0] a_err;

    // saturation instance: 2-bit error counter, slow loss of lock
    logic        b_reset = 1'b1;
    logic        b_valid = 1'b0;
    logic [15:0] b_count = '0;
    logic        b_clear = 1'b0;
    logic        b_locked;
    logic        b_error;
    logic [1:0]  b_err;

`ifdef COUNT_SEQUENCE_CHECKER_STATS_EN
    logic [15:0] a_good;
    logic [1:0]  b_good;
`endif

    int checks = 0;
    int errors = 0;

    count_sequence_checker #(
        .P_COUNT_W(16), .P_LOCK_N(4), .P_LOSS_N(3), .P_ERR_W(16)
    ) dut_a (
        .i_clk       (clk),
        .i_reset     (a_reset),
        .i_valid     (a_valid),
        .i_count     (a_count),
        .i_clear_err (a_clear),
        .o_locked    (a_locked),
        .o_error     (a_error),
        .o_err_count (a_err)
`ifdef COUNT_SEQUENCE_CHECKER_STATS_EN
        ,
        .o_good_count(a_good)
`endif
    );

    count_sequence_checker #(
        .P_COUNT_W(16), .P_LOCK_N(4), .P_LOSS_N(8), .P_ERR_W(2)
    ) dut_b (
        .i_clk       (clk),
        .i_reset     (b_reset),
        .i_valid     (b_valid),
        .i_count     (b_count),
        .i_clear_err (b_clear),
        .o_locked    (b_locked),
        .o_error     (b_error),
        .o_err_count (b_err)
`ifdef COUNT_SEQUENCE_CHECKER_STATS_EN
        ,
        .o_good_count(b_good)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one clock on instance A, outputs sampled 1 time unit after the edge
    task automatic step_a(input logic v, input logic [15:0] c, input logic clr, input logic rst);
        a_valid = v;
        a_count = c;
        a_clear = clr;
        a_reset = rst;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_clear = 1'b0;
        a_reset = 1'b0;
    endtask

    task automatic step_b(input logic v, input logic [15:0] c, input logic rst);
        b_valid = v;
        b_count = c;
        b_reset = rst;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_reset = 1'b0;
    endtask

    initial begin
        // reset both instances
        step_a(1'b0, 16'h0, 1'b0, 1'b1);
        step_b(1'b0, 16'h0, 1'b1);
        check("reset_locked", {31'd0, a_locked}, 32'd0);
        check("reset_error",  {31'd0, a_error},  32'd0);
        check("reset_err",    {16'd0, a_err},    32'd0);

        // lock across the 16-bit wrap
        step_a(1'b1, 16'hFFFE, 1'b0, 1'b0);
        step_a(1'b1, 16'hFFFF, 1'b0, 1'b0);
        step_a(1'b1, 16'h0000, 1'b0, 1'b0);
        check("wrap_not_yet", {31'd0, a_locked}, 32'd0);
        step_a(1'b1, 16'h0001, 1'b0, 1'b0);
        check("wrap_locked",  {31'd0, a_locked}, 32'd1);
        check("wrap_error",   {31'd0, a_error},  32'd0);
        check("wrap_err",     {16'd0, a_err},    32'd0);

        // single glitch: lock at 10..13, then 14, 99, 16, 17
        step_a(1'b0, 16'd0, 1'b0, 1'b1);
        for (int i = 10; i <= 14; i++) step_a(1'b1, 16'(i), 1'b0, 1'b0);
        check("glitch_pre_err", {31'd0, a_error}, 32'd0);
        step_a(1'b1, 16'd99, 1'b0, 1'b0);
        check("glitch_pulse",  {31'd0, a_error},  32'd1);
        check("glitch_err",    {16'd0, a_err},    32'd1);
        check("glitch_locked", {31'd0, a_locked}, 32'd1);
        step_a(1'b1, 16'd16, 1'b0, 1'b0);
        check("glitch_pulse_end", {31'd0, a_error}, 32'd0);
        step_a(1'b1, 16'd17, 1'b0, 1'b0);
        check("glitch_err_hold", {16'd0, a_err},  32'd1);

        // loss of lock: expected 18, feed 18,19, clear total, then 500..502
        step_a(1'b1, 16'd18, 1'b0, 1'b0);
        step_a(1'b1, 16'd19, 1'b0, 1'b0);
        step_a(1'b0, 16'd0, 1'b1, 1'b0);
        check("clear_alone", {16'd0, a_err}, 32'd0);
        step_a(1'b1, 16'd500, 1'b0, 1'b0);
        check("loss_pulse1", {31'd0, a_error}, 32'd1);
        step_a(1'b1, 16'd501, 1'b0, 1'b0);
        check("loss_locked2", {31'd0, a_locked}, 32'd1);
        step_a(1'b1, 16'd502, 1'b0, 1'b0);
        check("loss_pulse3", {31'd0, a_error},  32'd1);
        check("loss_err",    {16'd0, a_err},    32'd3);
        check("loss_unlock", {31'd0, a_locked}, 32'd0);
        step_a(1'b1, 16'd503, 1'b0, 1'b0);
        check("relock_no_err", {31'd0, a_error}, 32'd0);
        step_a(1'b1, 16'd504, 1'b0, 1'b0);
        check("relock_not_yet", {31'd0, a_locked}, 32'd0);
        step_a(1'b1, 16'd505, 1'b0, 1'b0);
        check("relock", {31'd0, a_locked}, 32'd1);

        // gated valid and SEEK resync
        step_a(1'b0, 16'd0, 1'b0, 1'b1);
        check("reset_mid_locked", {31'd0, a_locked}, 32'd0);
        check("reset_mid_err",    {16'd0, a_err},    32'd0);
        step_a(1'b1, 16'd0, 1'b0, 1'b0);
        step_a(1'b1, 16'd1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step_a(1'b0, 16'd3, 1'b0, 1'b0);
        check("gated_locked", {31'd0, a_locked}, 32'd0);
        step_a(1'b1, 16'd7, 1'b0, 1'b0);
        check("resync_no_err", {31'd0, a_error}, 32'd0);
        step_a(1'b1, 16'd8, 1'b0, 1'b0);
        step_a(1'b1, 16'd9, 1'b0, 1'b0);
        check("resync_not_yet", {31'd0, a_locked}, 32'd0);
        step_a(1'b1, 16'd10, 1'b0, 1'b0);
        check("resync_locked", {31'd0, a_locked}, 32'd1);
        check("resync_err",    {16'd0, a_err},    32'd0);

        // build err_count = 5 with alternating bad/good (expected starts at 11)
        step_a(1'b1, 16'd100, 1'b0, 1'b0);
        step_a(1'b1, 16'd12,  1'b0, 1'b0);
        step_a(1'b1, 16'd200, 1'b0, 1'b0);
        step_a(1'b1, 16'd14,  1'b0, 1'b0);
        step_a(1'b1, 16'd300, 1'b0, 1'b0);
        step_a(1'b1, 16'd16,  1'b0, 1'b0);
        step_a(1'b1, 16'd400, 1'b0, 1'b0);
        step_a(1'b1, 16'd18,  1'b0, 1'b0);
        step_a(1'b1, 16'd500, 1'b0, 1'b0);
        step_a(1'b1, 16'd20,  1'b0, 1'b0);
        check("build_err5",   {16'd0, a_err},    32'd5);
        check("build_locked", {31'd0, a_locked}, 32'd1);
        // clear collides with a bad sample
        step_a(1'b1, 16'd999, 1'b1, 1'b0);
        check("collide_err",   {16'd0, a_err},   32'd1);
        check("collide_pulse", {31'd0, a_error}, 32'd1);
        step_a(1'b0, 16'd0, 1'b1, 1'b0);
        check("collide_clear", {16'd0, a_err},    32'd0);
        check("clear_keeps_lock", {31'd0, a_locked}, 32'd1);
        check("idle_no_pulse", {31'd0, a_error},  32'd0);

        // saturation on a 2-bit counter
        for (int i = 0; i < 4; i++) step_b(1'b1, 16'(i), 1'b0);
        check("b_locked", {31'd0, b_locked}, 32'd1);
        step_b(1'b1, 16'd50, 1'b0);
        step_b(1'b1, 16'd60, 1'b0);
        step_b(1'b1, 16'd70, 1'b0);
        check("sat_err3", {30'd0, b_err}, 32'd3);
        step_b(1'b1, 16'd80, 1'b0);
        step_b(1'b1, 16'd90, 1'b0);
        check("sat_hold",   {30'd0, b_err},    32'd3);
        check("sat_pulse",  {31'd0, b_error},  32'd1);
        check("sat_locked", {31'd0, b_locked}, 32'd1);
        // reset mid-stream with valid high: the sample is ignored
        step_b(1'b1, 16'd100, 1'b1);
        check("b_rst_locked", {31'd0, b_locked}, 32'd0);
        check("b_rst_error",  {31'd0, b_error},  32'd0);
        check("b_rst_err",    {30'd0, b_err},    32'd0);
        // from IDLE, four good samples are needed again
        step_b(1'b1, 16'd101, 1'b0);
        step_b(1'b1, 16'd102, 1'b0);
        step_b(1'b1, 16'd103, 1'b0);
        check("b_idle_not_yet", {31'd0, b_locked}, 32'd0);
        step_b(1'b1, 16'd104, 1'b0);
        check("b_relock", {31'd0, b_locked}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
